booth_mul_seq: RTL



---
 rtl/mul_pkg.sv | 15 +
 rtl/addsub_n.sv | 13 +
 rtl/booth_mul_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiply unit: FSM state type and
// counter-width helper.
package mul_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Step counter must hold WIDTH+1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/addsub_n.sv
// N-bit adder/subtractor: out = a + b, or a - b as a + ~b + 1 when sub is set.
module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] out
);

  assign out = a + (sub ? ~b : b) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock, signed or unsigned
// operands, with start/busy/done handshake and a held registered product.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t        state, state_n;
  logic [W1-1:0] a_r, q_r, m_r;
  logic          q_1;
  logic [CW-1:0] count;
  logic [W1-1:0] mc_x, mp_x, sum, a_nxt;
  logic [2*W1:0] shifted;
  logic          last_step;

  assign mc_x = {mode_signed & mc[WIDTH-1], mc};
  assign mp_x = {mode_signed & mp[WIDTH-1], mp};

  // sub follows Q[0]: pair 10 subtracts, 01 adds; 00/11 bypass via the mux.
  addsub_n #(.N(W1)) u_addsub (
    .a   (a_r),
    .b   (m_r),
    .sub (q_r[0]),
    .out (sum)
  );

  assign a_nxt = (q_r[0] ^ q_1) ? sum : a_r;
  // Shift-in bit is the sign of the new sum, not of the old A.
  assign shifted   = {a_nxt[WIDTH], a_nxt, q_r};
  assign last_step = (state == ST_RUN) && (count == LAST);
  assign busy      = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start)     state_n = ST_RUN;
      ST_RUN:  if (last_step) state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      q_1   <= 1'b0;
      count <= '0;
      done  <= 1'b0;
      prod  <= '0;
    end else begin
      done <= last_step;
      if (state == ST_IDLE) begin
        if (start) begin
          m_r   <= mc_x;
          q_r   <= mp_x;
          a_r   <= '0;
          q_1   <= 1'b0;
          count <= '0;
        end
      end else begin
        a_r   <= shifted[2*W1:W1+1];
        q_r   <= shifted[W1:1];
        q_1   <= q_r[0];
        count <= count + 1'b1;
        if (last_step) prod <= shifted[2*WIDTH:1];
      end
    end
  end

endmodule
